// File: rtl/risc_pkg.sv
// Shared definitions for the RISC microcontroller control path: opcodes,
// instruction field positions, sequencer states and opcode classification.
package risc_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_DIV   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_BEQ   = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WAIT_ALU,
        MEM,
        WB,
        HALT,
        FAULT
    } state_t;

    function automatic logic is_single_alu(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT};
    endfunction

    function automatic logic is_writeback(input logic [3:0] op);
        return is_single_alu(op) || (op inside {OP_MUL, OP_DIV, OP_LOAD});
    endfunction

endpackage

// File: rtl/instr_sequencer_alu_watchdog.sv
// Watchdog for the multi-cycle ALU wait: counts enabled cycles since the last
// clear and flags the final permitted cycle.
module alu_watchdog #(
    parameter int ALU_TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count is the zero-based index of the current wait cycle.
    assign expired_o = enable_i && (count_q == CNT_W'(ALU_TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, ALU/memory handshakes,
// register write strobe and PC ownership.
//   state    | meaning
//   FETCH    | imem_req high, waiting for imem_valid
//   DECODE   | fields latched; branch/jump/NOP resolve the PC here
//   EXEC     | one-cycle alu_start pulse, watchdog cleared
//   WAIT_ALU | waiting for alu_done under watchdog
//   MEM      | dmem_req high, waiting for dmem_ready
//   WB       | write_enable pulse, PC advances
//   HALT     | halted, sticky until reset
//   FAULT    | fault, sticky until reset, PC holds faulting address
module instr_sequencer #(
    parameter int PC_W        = 8,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    input  logic            imem_valid,
    input  logic [15:0]     instr_in,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      opcode,
    output logic [3:0]      rd_addr,
    output logic [3:0]      rs1_addr,
    output logic [3:0]      rs2_addr,
    output logic            alu_start,
    input  logic            alu_done,
    input  logic            div_by_zero,
    input  logic            zero_flag,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            write_enable,
    output logic            halted,
    output logic            fault
);
    import risc_pkg::*;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      op_q, op_d;
    logic [3:0]      rd_q, rd_d;
    logic [3:0]      rs1_q, rs1_d;
    logic [3:0]      rs2_q, rs2_d;
    logic            wd_expired;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;

    assign pc_inc = pc_q + PC_W'(1);
    // Jump target is the rs1:rs2 byte, truncated or zero-extended to PC_W.
    assign target = PC_W'({rs1_q, rs2_q});

    alu_watchdog #(
        .ALU_TIMEOUT(ALU_TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk),
        .reset_i  (reset),
        .clear_i  (state_q == EXEC),
        .enable_i (state_q == WAIT_ALU),
        .expired_o(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        unique case (state_q)
            FETCH: begin
                if (imem_valid) begin
                    op_d    = instr_in[OPC_MSB:OPC_LSB];
                    rd_d    = instr_in[RD_MSB:RD_LSB];
                    rs1_d   = instr_in[RS1_MSB:RS1_LSB];
                    rs2_d   = instr_in[RS2_MSB:RS2_LSB];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_single_alu(op_q)) begin
                    state_d = WB;
                end else begin
                    case (op_q)
                        OP_MUL, OP_DIV:    state_d = EXEC;
                        OP_LOAD, OP_STORE: state_d = MEM;
                        OP_JMP: begin
                            pc_d    = target;
                            state_d = FETCH;
                        end
                        OP_BEQ: begin
                            pc_d    = zero_flag ? target : pc_inc;
                            state_d = FETCH;
                        end
                        OP_HALT:           state_d = HALT;
                        default: begin
                            pc_d    = pc_inc;
                            state_d = FETCH;
                        end
                    endcase
                end
            end
            EXEC: state_d = WAIT_ALU;
            WAIT_ALU: begin
                // A completion in the last permitted cycle beats the timeout.
                if (alu_done) begin
                    state_d = (op_q == OP_DIV && div_by_zero) ? FAULT : WB;
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    if (op_q == OP_STORE) begin
                        pc_d    = pc_inc;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                pc_d    = pc_inc;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            FAULT:   state_d = FAULT;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        imem_req     = 1'b0;
        alu_start    = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        write_enable = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        unique case (state_q)
            FETCH:    imem_req = 1'b1;
            EXEC:     alu_start = 1'b1;
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_STORE);
            end
            WB:       write_enable = is_writeback(op_q);
            HALT:     halted = 1'b1;
            FAULT:    fault = 1'b1;
            default:  ;
        endcase
    end

    assign pc       = pc_q;
    assign opcode   = op_q;
    assign rd_addr  = rd_q;
    assign rs1_addr = rs1_q;
    assign rs2_addr = rs2_q;

endmodule
